// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding and frame sizing for the UART transmitter
package uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + parity + stop_bits;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: enabled divider that pulses bit_tick once every DIV enabled cycles
module uart_baud_tick #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign bit_tick = en && cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= bit_tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: buffered UART transmitter with internal baud divider.
// Define TX_PARITY_EN to insert a parity bit after the data bits.
import uart_tx_pkg::*;
module uart_tx_frame #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_DIV = 16,
  parameter int STOP_BITS = 1
`ifdef TX_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load,
  output logic                 ready,
  input  logic                 transmit_enable,
  output logic                 data_out,
  output logic                 busy,
  output logic                 character_sent
);
`ifdef TX_PARITY_EN
  localparam int P = 1;
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam int P = 0;
  localparam tx_state_t AFTER_DATA = STOP;
`endif
  localparam int IW = $clog2(frame_bits(DATA_BITS, P, STOP_BITS));
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  tx_state_t state, state_n;
  logic [DATA_BITS-1:0] hold, shift;
  logic hold_valid, tick, last_stop, load_shift, accept;
  logic [IW-1:0] idx;
`ifdef TX_PARITY_EN
  logic par;
`endif
  assign ready = !hold_valid;
  assign accept = load && ready;
  assign busy = state != IDLE;
  assign character_sent = last_stop;
  assign load_shift = state_n == START && state != START;
  uart_baud_tick #(.DIV(BAUD_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .en(transmit_enable && state != IDLE),
    .clr(load_shift),
    .bit_tick(tick)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    last_stop = 1'b0;
    case (state)
      IDLE:   state_n = (hold_valid && transmit_enable) ? START : IDLE;
      START:  state_n = tick ? DATA : START;
      DATA:   state_n = (tick && idx == LAST_DATA) ? AFTER_DATA : DATA;
`ifdef TX_PARITY_EN
      PARITY: state_n = tick ? STOP : PARITY;
`endif
      STOP: begin
        last_stop = tick && idx == LAST_STOP;
        state_n = last_stop ? (hold_valid ? START : IDLE) : STOP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    data_out = 1'b1;
    if (state == START) data_out = 1'b0;
    if (state == DATA) data_out = shift[0];
`ifdef TX_PARITY_EN
    if (state == PARITY) data_out = par;
`endif
  end
  // ready is low whenever hold_valid is set, so accept and load_shift never coincide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= '0;
      hold_valid <= 1'b0;
      shift <= '0;
      idx <= '0;
    end else begin
      if (accept) begin
        hold <= data_in;
        hold_valid <= 1'b1;
      end else if (load_shift) hold_valid <= 1'b0;
      if (load_shift) shift <= hold;
      else if (tick && state == DATA) shift <= shift >> 1;
      if (load_shift) idx <= '0;
      else if (tick) idx <= (state_n != state) ? '0 : idx + 1'b1;
    end
  end
`ifdef TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par <= 1'b0;
    else if (load_shift) par <= ^hold ^ 1'(PARITY_ODD);
  end
`endif
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of framing, back-to-back, pause, handshake and reset
module tb_uart_tx_frame;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0, transmit_enable = 1'b1;
  logic [7:0] data_in = '0;
  logic ready, data_out, busy, character_sent;
  int n_cmp = 0, n_bad = 0;
  logic [127:0] line, exp_line;
  int sent_at, sent_last, sent_cnt;
  uart_tx_frame #(.DATA_BITS(8), .BAUD_DIV(4), .STOP_BITS(1)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .load(load),
    .ready(ready),
    .transmit_enable(transmit_enable),
    .data_out(data_out),
    .busy(busy),
    .character_sent(character_sent)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] expand(input logic [15:0] f, input int nb);
    logic [127:0] r = '0;
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < 4; j++) r[i*4+j] = f[i];
    return r;
  endfunction
  // samples the current cycle first, then n-1 more; load is dropped after the first edge
  task automatic capture(input int n);
    line = '0;
    sent_at = 0;
    sent_last = 0;
    sent_cnt = 0;
    for (int k = 0; k < n; k++) begin
      line[k] = data_out;
      if (character_sent) begin
        if (sent_cnt == 0) sent_at = k + 1;
        sent_last = k + 1;
        sent_cnt++;
      end
      step();
      load = 1'b0;
    end
  endtask
  task automatic start_frame(input logic [7:0] d);
    load = 1'b1;
    data_in = d;
    step();
    load = 1'b0;
    step();
  endtask
  initial begin
    #1;
    check("rst_data_out", data_out, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_sent", character_sent, 0);
    step();
    step();
    rst = 1'b1;
    step();
    load = 1'b1;
    data_in = 8'hA5;
    step();
    check("ready_after_accept", ready, 0);
    load = 1'b0;
    step();
    check("ready_at_start", ready, 1);
    capture(40);
    check("a5_line", line, expand({1'b1, 8'hA5, 1'b0}, 10));
    check("a5_sent_at", sent_at, 40);
    check("a5_sent_cnt", sent_cnt, 1);
    check("a5_idle_after", busy, 0);
    start_frame(8'h0F);
    load = 1'b1;
    data_in = 8'hF0;
    capture(80);
    exp_line = expand({1'b1, 8'h0F, 1'b0}, 10) | (expand({1'b1, 8'hF0, 1'b0}, 10) << 40);
    check("b2b_line", line, exp_line);
    check("b2b_sent_cnt", sent_cnt, 2);
    check("b2b_first_sent", sent_at, 40);
    check("b2b_gap", sent_last - sent_at, 40);
    check("b2b_idle_after", busy, 0);
    start_frame(8'h11);
    load = 1'b1;
    data_in = 8'h22;
    step();
    check("hs_full_ready", ready, 0);
    data_in = 8'h33;
    step();
    load = 1'b0;
    capture(78);
    exp_line = (expand({1'b1, 8'h11, 1'b0}, 10) | (expand({1'b1, 8'h22, 1'b0}, 10) << 40)) >> 2;
    check("hs_line", line, exp_line);
    check("hs_sent_cnt", sent_cnt, 2);
    check("hs_no_third", busy, 0);
    start_frame(8'h55);
    exp_line = expand({1'b1, 8'h55, 1'b0}, 10);
    capture(17);
    check("pause_pre", line, exp_line & ((128'd1 << 17) - 1));
    transmit_enable = 1'b0;
    capture(10);
    check("pause_hold", line, 0);
    check("pause_busy", busy, 1);
    transmit_enable = 1'b1;
    capture(23);
    check("pause_post", line, exp_line >> 17);
    check("pause_sent_at", sent_at, 23);
    check("pause_sent_cnt", sent_cnt, 1);
    start_frame(8'hFF);
    capture(26);
    #3 rst = 1'b0;
    #1;
    check("arst_data_out", data_out, 1);
    check("arst_ready", ready, 1);
    check("arst_busy", busy, 0);
    check("arst_sent", character_sent, 0);
    step();
    step();
    rst = 1'b1;
    step();
    start_frame(8'h01);
    capture(40);
    check("post_rst_line", line, expand({1'b1, 8'h01, 1'b0}, 10));
    check("post_rst_sent_at", sent_at, 40);
`ifdef TX_PARITY_EN
    start_frame(8'hA5);
    capture(44);
    check("par_line", line, expand({1'b1, 1'b0, 8'hA5, 1'b0}, 11));
    check("par_sent_at", sent_at, 44);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
